// File: rtl/ssd_pkg.sv
// Shared seven-segment constants and helpers for the BCD timer display.
// Segment vectors are active-low {a,b,c,d,e,f,g,dp}; dp is always off.
package ssd_pkg;

  localparam logic [3:0] BLANK   = 4'hF;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  localparam logic [7:0] SEG_0 = 8'h03;
  localparam logic [7:0] SEG_1 = 8'h9F;
  localparam logic [7:0] SEG_2 = 8'h25;
  localparam logic [7:0] SEG_3 = 8'h0D;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h49;
  localparam logic [7:0] SEG_6 = 8'h41;
  localparam logic [7:0] SEG_7 = 8'h1F;
  localparam logic [7:0] SEG_8 = 8'h01;
  localparam logic [7:0] SEG_9 = 8'h09;

  localparam logic [3:0] DIG_EN0 = 4'b1110;
  localparam logic [3:0] DIG_EN1 = 4'b1101;
  localparam logic [3:0] DIG_EN2 = 4'b1011;
  localparam logic [3:0] DIG_EN3 = 4'b0111;

  function automatic logic [7:0] seg_decode(input logic [3:0] code);
    logic [7:0] seg;
    case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

  function automatic logic [3:0] digit_enable(input logic [1:0] slot);
    logic [3:0] en;
    unique case (slot)
      2'd0:    en = DIG_EN0;
      2'd1:    en = DIG_EN1;
      2'd2:    en = DIG_EN2;
      default: en = DIG_EN3;
    endcase
    return en;
  endfunction

  function automatic logic [3:0] clamp_bcd(input logic [3:0] nib);
    return (nib > 4'd9) ? 4'd9 : nib;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD nibble of the up/down chain: next value plus carry/borrow out.
// A step only happens when cin is high; cout marks a 9->0 or 0->9 roll.
module bcd_digit (
  input  logic [3:0] digit,
  input  logic       inc,
  input  logic       dec,
  input  logic       cin,
  output logic [3:0] value,
  output logic       cout
);

  always_comb begin
    value = digit;
    cout  = 1'b0;
    if (cin && inc) begin
      if (digit >= 4'd9) begin
        value = 4'd0;
        cout  = 1'b1;
      end else begin
        value = digit + 4'd1;
      end
    end else if (cin && dec) begin
      if (digit == 4'd0) begin
        value = 4'd9;
        cout  = 1'b1;
      end else begin
        value = digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_timer_display.sv
// N-digit BCD up/down timer with tick prescaler, wrap/saturate boundary
// handling, and a 4-digit multiplexed seven-segment scan driver.
module bcd_timer_display
  import ssd_pkg::*;
#(
  parameter int unsigned           DIGITS   = 2,
  parameter int unsigned           TICK_DIV = 100_000_000,
  parameter int unsigned           SCAN_DIV = 100_000,
  parameter bit                    WRAP     = 1'b0,
  parameter logic [4*DIGITS-1:0]   RST_VAL  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  done,
  output logic [15:0]           led,
  output logic [7:0]            segs,
  output logic [3:0]            ssd_ctl
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};
  localparam logic [7:0] SEG_RST = seg_decode(RST_VAL[3:0]);

  logic [PW-1:0]       presc_q, presc_d;
  logic [4*DIGITS-1:0] count_q, count_d;
  logic                done_q, done_d;
  logic                tc_q, tc_d;
  logic [15:0]         led_q;
  logic [SW-1:0]       scan_cnt_q;
  logic [1:0]          slot_q;
  logic [7:0]          segs_q;
  logic [3:0]          ssd_ctl_q;

  logic                tick;
  logic [4*DIGITS-1:0] step_val;
  logic [4*DIGITS-1:0] load_clamped;
  logic [DIGITS:0]     carry;
  logic [15:0]         disp;

  assign tick     = (presc_q == PRESC_MAX);
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .digit (count_q[4*i +: 4]),
      .inc   (up),
      .dec   (~up),
      .cin   (carry[i]),
      .value (step_val[4*i +: 4]),
      .cout  (carry[i+1])
    );
    assign load_clamped[4*i +: 4] = clamp_bcd(load_val[4*i +: 4]);
  end

  // Display slots beyond the counted digits show the blank code.
  for (genvar k = 0; k < 4; k++) begin : g_disp
    if (k < DIGITS) begin : g_live
      assign disp[4*k +: 4] = count_q[4*k +: 4];
    end else begin : g_blank
      assign disp[4*k +: 4] = BLANK;
    end
  end

  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    count_d = count_q;
    done_d  = done_q;
    tc_d    = 1'b0;
    if (load) begin
      count_d = load_clamped;
      presc_d = '0;
      done_d  = 1'b0;
    end else if (tick && en) begin
      if (carry[DIGITS]) begin
        // Stepping past the boundary: wrap, or saturate and flag once.
        if (WRAP) begin
          count_d = step_val;
          tc_d    = 1'b1;
        end else begin
          done_d = 1'b1;
          tc_d   = ~done_q;
        end
      end else begin
        count_d = step_val;
        if (!WRAP && (step_val == (up ? ALL_NINES : '0))) begin
          done_d = 1'b1;
          tc_d   = ~done_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      count_q    <= RST_VAL;
      done_q     <= 1'b0;
      tc_q       <= 1'b0;
      led_q      <= '0;
      scan_cnt_q <= '0;
      slot_q     <= '0;
      segs_q     <= SEG_RST;
      ssd_ctl_q  <= DIG_EN0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      done_q  <= done_d;
      tc_q    <= tc_d;
      led_q   <= {16{done_d}};
      if (scan_cnt_q == SCAN_MAX) begin
        scan_cnt_q <= '0;
        slot_q     <= slot_q + 2'd1;
      end else begin
        scan_cnt_q <= scan_cnt_q + 1'b1;
      end
      segs_q    <= seg_decode(disp[{slot_q, 2'b00} +: 4]);
      ssd_ctl_q <= digit_enable(slot_q);
    end
  end

  assign count   = count_q;
  assign tc      = tc_q;
  assign done    = done_q;
  assign led     = led_q;
  assign segs    = segs_q;
  assign ssd_ctl = ssd_ctl_q;

endmodule

// File: tb/tb_bcd_timer_display.sv
// Directed bench: saturating instance (RST_VAL 30) and wrapping instance.
module tb_bcd_timer_display;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        en0, up0, load0, en1, up1, load1;
  logic [7:0]  load_val0, load_val1;
  logic [7:0]  count0, count1, segs0, segs1;
  logic        tc0, tc1, done0, done1;
  logic [15:0] led0, led1;
  logic [3:0]  ssd0, ssd1;

  bcd_timer_display #(
    .DIGITS(2), .TICK_DIV(4), .SCAN_DIV(2), .WRAP(1'b0), .RST_VAL(8'h30)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en0), .up(up0), .load(load0), .load_val(load_val0),
    .count(count0), .tc(tc0), .done(done0), .led(led0), .segs(segs0), .ssd_ctl(ssd0)
  );

  bcd_timer_display #(
    .DIGITS(2), .TICK_DIV(4), .SCAN_DIV(2), .WRAP(1'b1), .RST_VAL(8'h00)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .up(up1), .load(load1), .load_val(load_val1),
    .count(count1), .tc(tc1), .done(done1), .led(led1), .segs(segs1), .ssd_ctl(ssd1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  logic [3:0] prev_ctl;
  int         run;
  bit         seen_change;
  bit         found;

  initial begin
    rst_n = 1'b0;
    en0 = 1'b1; up0 = 1'b0; load0 = 1'b0; load_val0 = 8'h00;
    en1 = 1'b0; up1 = 1'b1; load1 = 1'b0; load_val1 = 8'h00;
    #12;
    check_eq("rst_count", count0, 8'h30);
    check_eq("rst_tc", tc0, 1'b0);
    check_eq("rst_done", done0, 1'b0);
    check_eq("rst_led", led0, 16'h0000);
    check_eq("rst_ssd", ssd0, 4'b1110);
    check_eq("rst_segs", segs0, 8'h03);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Saturating count down 30 -> 00, one step per 4 cycles.
    for (int i = 29; i >= 0; i--) begin
      step(4);
      check_eq("down_count", count0, bcd2(i));
      check_eq("down_tc", tc0, (i == 0) ? 1'b1 : 1'b0);
      check_eq("down_done", done0, (i == 0) ? 1'b1 : 1'b0);
      check_eq("down_led", led0, (i == 0) ? 16'hFFFF : 16'h0000);
    end
    for (int i = 0; i < 3; i++) begin
      step(4);
      check_eq("hold_count", count0, 8'h00);
      check_eq("hold_tc", tc0, 1'b0);
      check_eq("hold_done", done0, 1'b1);
    end

    // Load coincident with a tick: clamped, prescaler restarts, done cleared.
    step(3);
    load0 = 1'b1; load_val0 = 8'h5F;
    step(1);
    load0 = 1'b0;
    check_eq("ld_count", count0, 8'h59);
    check_eq("ld_done", done0, 1'b0);
    check_eq("ld_led", led0, 16'h0000);
    check_eq("ld_tc", tc0, 1'b0);
    step(3);
    check_eq("ld_restart", count0, 8'h59);
    step(1);
    check_eq("ld_next", count0, 8'h58);

    // Frozen count while the scan keeps rotating.
    en0 = 1'b0;
    prev_ctl = ssd0; run = 0; seen_change = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check_eq("frz_count", count0, 8'h58);
      if (ssd0 != prev_ctl) begin
        check_eq("scan_rot", ssd0, {prev_ctl[2:0], prev_ctl[3]});
        if (seen_change) check_eq("scan_period", run, 2);
        seen_change = 1'b1;
        run = 1;
      end else begin
        run++;
      end
      prev_ctl = ssd0;
      case (ssd0)
        4'b1110: check_eq("scan_d0", segs0, 8'h01);
        4'b1101: check_eq("scan_d1", segs0, 8'h49);
        default: check_eq("scan_blank", segs0, 8'hFF);
      endcase
    end

    // Glyphs for 47.
    load0 = 1'b1; load_val0 = 8'h47;
    step(1);
    load0 = 1'b0;
    check_eq("ld47", count0, 8'h47);
    step(1);
    for (int i = 0; i < 8; i++) begin
      step(1);
      check_eq("dp_off", segs0[0], 1'b1);
      if (ssd0 == 4'b1110) check_eq("g7", segs0, 8'h1F);
      if (ssd0 == 4'b1101) check_eq("g4", segs0, 8'h99);
    end

    // Wrapping instance.
    en1 = 1'b1; up1 = 1'b1; load1 = 1'b1; load_val1 = 8'h98;
    step(1);
    load1 = 1'b0;
    check_eq("w_load", count1, 8'h98);
    step(4);
    check_eq("w_99", count1, 8'h99);
    check_eq("w_99_tc", tc1, 1'b0);
    check_eq("w_99_done", done1, 1'b0);
    step(4);
    check_eq("w_wrap", count1, 8'h00);
    check_eq("w_wrap_tc", tc1, 1'b1);
    check_eq("w_wrap_done", done1, 1'b0);
    up1 = 1'b0;
    step(4);
    check_eq("w_under", count1, 8'h99);
    check_eq("w_under_tc", tc1, 1'b1);
    check_eq("w_under_done", done1, 1'b0);
    step(4);
    check_eq("w_98", count1, 8'h98);
    check_eq("w_98_tc", tc1, 1'b0);

    // Asynchronous reset mid-scan.
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!found) begin
        step(1);
        if (ssd0 == 4'b1101) found = 1'b1;
      end
    end
    check_eq("scan_found", found, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_ssd", ssd0, 4'b1110);
    check_eq("arst_count0", count0, 8'h30);
    check_eq("arst_count1", count1, 8'h00);
    check_eq("arst_segs", segs0, 8'h03);
    check_eq("arst_done", done0, 1'b0);
    check_eq("arst_tc", tc1, 1'b0);
    #10;
    rst_n = 1'b1;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_timer_display.md
# bcd_timer_display

Parametrised N-digit BCD up/down timer with integrated 4-digit seven-segment scan driver, the successor to the fixed two-digit down-counter display top. One block contains the count-tick prescaler, a DIGITS-wide BCD counter with load, direction, wrap/saturate mode, done/terminal-count flags and LED bar, plus the digit multiplexer and segment decoder. It sits directly under the board top, driving the on-board 7-segment display and LEDs.

## Interface
- DIGITS, 2: BCD digits counted, 1..4; display digits above DIGITS are blanked.
- TICK_DIV, 100_000_000: clk cycles per count tick (1 Hz at 100 MHz); ≥2.
- SCAN_DIV, 100_000: clk cycles per display digit slot; ≥2.
- WRAP, 0: 1 = wrap at boundary; 0 = saturate and hold.
- RST_VAL, 0: reset count, 4*DIGITS bits BCD, each nibble ≤9.
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  count enable; sampled on tick cycles.
- up  in  1  1 = count up, 0 = count down.
- load  in  1  synchronous load strobe.
- load_val  in  4*DIGITS  BCD load value.
- count  out  4*DIGITS  current BCD count.
- tc  out  1  one-cycle terminal-count pulse.
- done  out  1  sticky boundary flag.
- led  out  16  LED bar, all ones while done, else zero.
- segs  out  8  active-low {a,b,c,d,e,f,g,dp}; dp always 1.
- ssd_ctl  out  4  active-low one-hot digit enable; bit 0 = rightmost digit.

## Operation
- Prescaler 0..TICK_DIV-1; tick is high the single cycle prescaler = TICK_DIV-1, then prescaler returns to 0.
- Priority per cycle: load > (tick & en) > hold.
- Load: count <= load_val, nibbles >9 clamped to 9; prescaler <= 0; done <= 0; tc <= 0.
- Tick & en & up: BCD increment, ripple carry digit to digit. From all-9s: WRAP=1 -> 0, tc=1; WRAP=0 -> hold, done=1, tc=1 only on the first arrival (done was 0).
- Tick & en & !up: BCD decrement with borrow. From 0: WRAP=1 -> all-9s, tc=1; WRAP=0 -> hold, done=1, tc=1 only if done was 0.
- WRAP=0 also sets done and pulses tc on the step that lands exactly on the boundary (e.g. 01 -> 00 counting down); subsequent ticks hold without tc.
- done clears only on load or reset; direction change does not clear it but count resumes moving away from boundary if en.
- en low: count and done frozen; prescaler keeps running.
- Scan: slot counter advances every SCAN_DIV cycles through digit 0,1,2,3,0...; digit k shows count nibble k if k<DIGITS, else blank (all segs 1).
- Decoder: 0-9 standard glyphs; any other code blank.

## Timing
- Reset: count = RST_VAL, prescaler 0, scan slot 0, tc 0, done 0, led 0, ssd_ctl 4'b1110, segs = glyph of RST_VAL[3:0].
- count, done, led, tc registered; update the cycle after tick or load is sampled (1-cycle latency).
- segs/ssd_ctl registered; change together, 1 cycle after slot advance; no overlap between digits.
- Reset asserted mid-count or mid-scan returns every output to reset values immediately (asynchronously).

## Structure
- Shared package/include ssd_pkg: segment glyph constants 0-9, BLANK code 4'hF, SEG_OFF 8'hFF, digit-enable one-hot constants.
- Sub-module bcd_digit: one nibble, inputs inc/dec/carry-in, outputs value and carry/borrow-out; instantiated DIGITS times via generate.
- Prescaler, scan counter, mux and decoder live in the top block.

## Test plan
- Bench uses TICK_DIV=4, SCAN_DIV=2, DIGITS=2.
- Reset with RST_VAL=8'h30, up=0, en=1 -> count 30,29,...,00 one step per 4 cycles; tc single pulse at 01->00, done=1, led=16'hFFFF, count holds 00 thereafter.
- WRAP=1, load 8'h98, up=1 -> 99 then 00 with tc pulse on wrap, done stays 0; up=0 at 00 -> 99 with tc.
- load asserted same cycle as tick with load_val=8'h5F -> count 59 (clamped), prescaler restarts, done cleared, no step that cycle.
- en=0 for 20 cycles -> count frozen; scan continues: ssd_ctl 1110,1101,1011,0111 every 2 cycles, digits 2,3 segs 8'hFF.
- count=8'h47 -> slot 0 segs=glyph 7, slot 1 segs=glyph 4, dp bit 1; rst_n low mid-scan -> ssd_ctl 1110 and count RST_VAL same cycle.
